// File: rtl/if_prefetch_unit.sv
// Instruction-fetch frontend: PC generator, credit-limited memory requests and a
// prefetch queue toward ID; redirects flush the queue and drop stale responses by count.
module if_prefetch_unit #(
  parameter logic [31:0] RESET_ADDR      = 32'h00000000,
  parameter int          QUEUE_DEPTH     = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_redirect,
  input  logic [31:0]                  i_redirect_target,
  output logic                         o_req_valid,
  output logic [31:0]                  o_req_addr,
  input  logic                         i_req_ready,
  input  logic                         i_resp_valid,
  input  logic [31:0]                  i_resp_data,
  output logic                         o_inst_valid,
  output logic [31:0]                  o_inst,
  output logic [31:0]                  o_inst_pc,
  input  logic                         i_inst_ready,
  output logic [$clog2(QUEUE_DEPTH):0] o_queue_count,
  output logic                         o_busy
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam int CW = AW + 1;
  localparam int OW = 3;
  localparam int SW = CW + OW;

  logic [31:0]   pc, pc_next;
  logic [31:0]   resp_pc, resp_pc_next;
  logic [AW-1:0] head, head_next;
  logic [AW-1:0] tail, tail_next;
  logic [CW-1:0] count, count_next;
  logic [OW-1:0] outstanding, outstanding_next;
  logic [OW-1:0] drop_cnt, drop_cnt_next;
  logic [31:0]   inst_mem [QUEUE_DEPTH];
  logic [31:0]   pc_mem   [QUEUE_DEPTH];

  logic [31:0]   target_aligned;
  logic [SW-1:0] credit_used;
  logic          can_req;
  logic          fire;
  logic          resp_live;
  logic          resp_drop;
  logic          push;
  logic          pop;

  // Credits count queue entries plus live (non-dropped) in-flight requests, so a
  // live response always finds a free slot.
  assign credit_used    = SW'(count) + SW'(outstanding) - SW'(drop_cnt);
  assign can_req        = (outstanding < OW'(MAX_OUTSTANDING)) && (credit_used < SW'(QUEUE_DEPTH));
  assign o_req_valid    = !i_rst && can_req;
  assign o_req_addr     = pc;
  assign fire           = o_req_valid && i_req_ready;
  assign target_aligned = i_redirect_target & ~32'h00000003;

  // A response needs a matching request, counting one accepted this same cycle.
  assign resp_live = i_resp_valid && ((outstanding != {OW{1'b0}}) || fire);
  assign resp_drop = resp_live && (drop_cnt != {OW{1'b0}});
  assign push      = resp_live && (drop_cnt == {OW{1'b0}}) && !i_redirect;
  assign pop       = (count != {CW{1'b0}}) && i_inst_ready && !i_redirect;

  assign outstanding_next = outstanding + OW'(fire) - OW'(resp_live);

  assign o_inst_valid  = (count != {CW{1'b0}});
  assign o_inst        = inst_mem[head];
  assign o_inst_pc     = pc_mem[head];
  assign o_queue_count = count;
  assign o_busy        = (outstanding != {OW{1'b0}});

  // Next-state selection; a redirect overrides every normal update.
  always_comb begin
    pc_next       = pc;
    resp_pc_next  = resp_pc;
    head_next     = head;
    tail_next     = tail;
    count_next    = count;
    drop_cnt_next = drop_cnt;
    if (i_redirect) begin
      pc_next       = target_aligned;
      resp_pc_next  = target_aligned;
      head_next     = {AW{1'b0}};
      tail_next     = {AW{1'b0}};
      count_next    = {CW{1'b0}};
      drop_cnt_next = outstanding_next;
    end else begin
      if (fire) begin
        pc_next = pc + 32'd4;
      end else begin
        pc_next = pc;
      end
      if (push) begin
        tail_next    = tail + AW'(1'b1);
        resp_pc_next = resp_pc + 32'd4;
      end else begin
        tail_next    = tail;
        resp_pc_next = resp_pc;
      end
      if (pop) begin
        head_next = head + AW'(1'b1);
      end else begin
        head_next = head;
      end
      count_next = count + CW'(push) - CW'(pop);
      if (resp_drop) begin
        drop_cnt_next = drop_cnt - 3'd1;
      end else begin
        drop_cnt_next = drop_cnt;
      end
    end
  end

  // Control state with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pc          <= RESET_ADDR;
      resp_pc     <= RESET_ADDR;
      head        <= {AW{1'b0}};
      tail        <= {AW{1'b0}};
      count       <= {CW{1'b0}};
      outstanding <= {OW{1'b0}};
      drop_cnt    <= {OW{1'b0}};
    end else begin
      pc          <= pc_next;
      resp_pc     <= resp_pc_next;
      head        <= head_next;
      tail        <= tail_next;
      count       <= count_next;
      outstanding <= outstanding_next;
      drop_cnt    <= drop_cnt_next;
    end
  end

  // Queue payload storage; contents are meaningless until count says otherwise.
  always_ff @(posedge i_clk) begin
    if (push) begin
      inst_mem[tail] <= i_resp_data;
      pc_mem[tail]   <= resp_pc;
    end
  end

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Self-checking bench for if_prefetch_unit: memory model with in-order responses,
// scoreboard of expected instructions, phase table plus hand-written corner cases.
module tb_if_prefetch_unit;
  localparam logic [31:0] RST_ADDR = 32'hFFFFFFF8;
  localparam int          DEPTH    = 4;
  localparam int          MAXO     = 2;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_target = 32'h0;
  logic        o_req_valid;
  logic [31:0] o_req_addr;
  logic        i_req_ready = 1'b0;
  logic        i_resp_valid = 1'b0;
  logic [31:0] i_resp_data = 32'h0;
  logic        o_inst_valid;
  logic [31:0] o_inst;
  logic [31:0] o_inst_pc;
  logic        i_inst_ready = 1'b0;
  logic [2:0]  o_queue_count;
  logic        o_busy;

  if_prefetch_unit #(
    .RESET_ADDR(RST_ADDR), .QUEUE_DEPTH(DEPTH), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_redirect(i_redirect),
    .i_redirect_target(i_redirect_target), .o_req_valid(o_req_valid),
    .o_req_addr(o_req_addr), .i_req_ready(i_req_ready), .i_resp_valid(i_resp_valid),
    .i_resp_data(i_resp_data), .o_inst_valid(o_inst_valid), .o_inst(o_inst),
    .o_inst_pc(o_inst_pc), .i_inst_ready(i_inst_ready), .o_queue_count(o_queue_count),
    .o_busy(o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct packed { logic [31:0] addr; logic [15:0] tag; } req_t;
  typedef struct packed { logic [31:0] data; logic [31:0] pc; } inst_t;
  typedef struct {
    int   cycles;
    logic req_ready;
    logic inst_ready;
    logic resp_en;
    int   exp_count;
    logic exp_busy;
    logic exp_req_valid;
  } phase_t;

  req_t        pending[$];
  inst_t       exp_q[$];
  req_t        cur_resp;
  bit          have_resp = 1'b0;
  bit          resp_en = 1'b0;
  logic [15:0] epoch = 16'd0;
  logic [31:0] exp_pc = RST_ADDR;
  int          n_checks = 0;
  int          n_fail = 0;
  phase_t      phases[6];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h13579BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Mid-cycle: check pops and fetch addresses, then update the memory/queue model.
  task automatic observe();
    inst_t e;
    if (i_rst) begin
      pending.delete();
      exp_q.delete();
      have_resp = 1'b0;
      epoch     = epoch + 16'd1;
      exp_pc    = RST_ADDR;
    end else begin
      if (o_inst_valid && i_inst_ready && !i_redirect) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_inst_pc", o_inst_pc, 32'hDEADDEAD);
        end else begin
          e = exp_q.pop_front();
          chk("inst_pc", o_inst_pc, e.pc);
          chk("inst_data", o_inst, e.data);
        end
      end
      if (i_resp_valid && have_resp && cur_resp.tag == epoch && !i_redirect)
        exp_q.push_back({mem_word(cur_resp.addr), cur_resp.addr});
      if (o_req_valid && i_req_ready) begin
        chk("req_addr", o_req_addr, exp_pc);
        pending.push_back({o_req_addr, epoch});
        exp_pc = exp_pc + 32'd4;
      end
      if (i_redirect) begin
        epoch  = epoch + 16'd1;
        exp_q.delete();
        exp_pc = i_redirect_target & ~32'h3;
      end
    end
  endtask

  task automatic post_checks();
    int live;
    int outs;
    if (i_rst) begin
      chk("rst_req_valid", 32'(o_req_valid), 32'd0);
      chk("rst_inst_valid", 32'(o_inst_valid), 32'd0);
      chk("rst_queue_count", 32'(o_queue_count), 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
    end else begin
      live = 0;
      outs = pending.size() + (have_resp ? 1 : 0);
      foreach (pending[i]) if (pending[i].tag == epoch) live++;
      if (have_resp && cur_resp.tag == epoch) live++;
      chk("queue_count", 32'(o_queue_count), 32'(exp_q.size()));
      chk("inst_valid", 32'(o_inst_valid), 32'(exp_q.size() != 0));
      chk("busy", 32'(o_busy), 32'(outs != 0));
      chk("credit_req_valid", 32'(o_req_valid), 32'((outs < MAXO) && (exp_q.size() + live < DEPTH)));
    end
  endtask

  task automatic tick();
    @(negedge i_clk);
    observe();
    @(posedge i_clk);
    #1;
    if (!i_rst && resp_en && pending.size() > 0) begin
      cur_resp     = pending.pop_front();
      have_resp    = 1'b1;
      i_resp_valid = 1'b1;
      i_resp_data  = mem_word(cur_resp.addr);
    end else begin
      have_resp    = 1'b0;
      i_resp_valid = 1'b0;
      i_resp_data  = 32'h0;
    end
    post_checks();
  endtask

  task automatic redirect_to(input logic [31:0] target);
    i_redirect        = 1'b1;
    i_redirect_target = target;
    tick();
    i_redirect        = 1'b0;
  endtask

  task automatic wait_inst(input string name, input logic [31:0] pc_v);
    int k;
    k = 0;
    while (!o_inst_valid && k < 10) begin
      tick();
      k++;
    end
    if (o_inst_valid) begin
      chk(name, o_inst_pc, pc_v);
    end else begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no instruction within 10 cycles, expected pc %h", name, pc_v);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a0;
    // {cycles, req_ready, inst_ready, resp_en, count, busy, req_valid}
    phases[0] = '{6,  1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1};
    phases[1] = '{20, 1'b1, 1'b0, 1'b1, 4, 1'b0, 1'b0};
    phases[2] = '{8,  1'b1, 1'b1, 1'b1, 2, 1'b1, 1'b1};
    phases[3] = '{5,  1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1};
    phases[4] = '{4,  1'b1, 1'b1, 1'b0, 0, 1'b1, 1'b0};
    phases[5] = '{6,  1'b1, 1'b1, 1'b1, 1, 1'b1, 1'b1};

    i_rst = 1'b1;
    repeat (2) tick();
    i_rst = 1'b0;
    i_inst_ready = 1'b1;
    i_req_ready  = 1'b1;
    resp_en      = 1'b1;

    // Fetch addresses wrap through the top of the address space.
    chk("wrap_addr0", o_req_addr, 32'hFFFFFFF8);
    tick();
    chk("wrap_addr1", o_req_addr, 32'hFFFFFFFC);
    tick();
    chk("wrap_addr2", o_req_addr, 32'h00000000);

    for (int p = 0; p < 6; p++) begin
      i_req_ready  = phases[p].req_ready;
      i_inst_ready = phases[p].inst_ready;
      resp_en      = phases[p].resp_en;
      repeat (phases[p].cycles) tick();
      chk($sformatf("phase%0d_count", p), 32'(o_queue_count), 32'(phases[p].exp_count));
      chk($sformatf("phase%0d_busy", p), 32'(o_busy), 32'(phases[p].exp_busy));
      chk($sformatf("phase%0d_req_valid", p), 32'(o_req_valid), 32'(phases[p].exp_req_valid));
    end

    // Memory stall holds the fetch address; accept advances it once.
    i_req_ready = 1'b0;
    a0 = o_req_addr;
    repeat (5) begin
      tick();
      chk("stall_addr", o_req_addr, a0);
    end
    i_req_ready = 1'b1;
    tick();
    chk("stall_release_addr", o_req_addr, a0 + 32'd4);

    // Two requests in flight at 0x10/0x14, then redirect to an unaligned target.
    i_req_ready = 1'b0;
    repeat (4) tick();
    redirect_to(32'h00000010);
    resp_en     = 1'b0;
    i_req_ready = 1'b1;
    repeat (2) tick();
    chk("two_out_busy", 32'(o_busy), 32'd1);
    chk("two_out_req_valid", 32'(o_req_valid), 32'd0);
    chk("two_out_next_addr", o_req_addr, 32'h00000018);
    i_req_ready = 1'b0;
    resp_en     = 1'b1;
    redirect_to(32'h00000103);
    tick();
    chk("drop_busy_mid", 32'(o_busy), 32'd1);
    tick();
    chk("drop_busy_clear", 32'(o_busy), 32'd0);
    chk("drop_queue_empty", 32'(o_queue_count), 32'd0);
    chk("drop_req_addr", o_req_addr, 32'h00000100);
    i_req_ready = 1'b1;
    wait_inst("redirect_first_pc", 32'h00000100);

    // Redirect coinciding with a request fire and a response arrival.
    repeat (4) tick();
    chk("same_cycle_pre_req_valid", 32'(o_req_valid), 32'd1);
    chk("same_cycle_pre_busy", 32'(o_busy), 32'd1);
    redirect_to(32'h00000200);
    chk("same_cycle_queue_count", 32'(o_queue_count), 32'd0);
    chk("same_cycle_inst_valid", 32'(o_inst_valid), 32'd0);
    chk("same_cycle_busy", 32'(o_busy), 32'd1);
    chk("same_cycle_req_addr", o_req_addr, 32'h00000200);
    wait_inst("same_cycle_first_pc", 32'h00000200);

    // Reset while two requests are outstanding.
    resp_en = 1'b0;
    repeat (3) tick();
    chk("pre_rst_busy", 32'(o_busy), 32'd1);
    chk("pre_rst_req_valid", 32'(o_req_valid), 32'd0);
    i_rst = 1'b1;
    tick();
    i_rst   = 1'b0;
    resp_en = 1'b1;
    chk("post_rst_addr", o_req_addr, RST_ADDR);
    wait_inst("post_rst_first_pc", RST_ADDR);

    i_req_ready = 1'b0;
    repeat (6) tick();
    chk("final_queue_empty", 32'(o_queue_count), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/if_prefetch_unit.md
Name: if_prefetch_unit

Overview:
Parametrised instruction-fetch frontend with a PC generator, a bounded number of in-flight memory requests and a DEPTH-entry prefetch queue. It feeds the ID stage through a valid/ready handshake. On a branch or jump redirect it flushes the queue in the same cycle and discards stale in-flight responses by count. It sits between the instruction memory/cache port and the ID stage.

Parameters:
RESET_ADDR, 32'h00000000, PC value loaded on reset
QUEUE_DEPTH, 4, prefetch queue entries; power of 2, >= 2
MAX_OUTSTANDING, 2, max accepted-but-unanswered memory requests; 1..4

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_redirect  in  1  flush and restart fetch at i_redirect_target
i_redirect_target  in  32  new fetch PC; bits [1:0] forced to 0
o_req_valid  out  1  memory read request valid
o_req_addr  out  32  word-aligned fetch address
i_req_ready  in  1  memory accepts request (fire = valid & ready)
i_resp_valid  in  1  read data returned, strictly in request order
i_resp_data  in  32  instruction word
o_inst_valid  out  1  queue head valid to ID
o_inst  out  32  head instruction
o_inst_pc  out  32  PC of head instruction
i_inst_ready  in  1  ID consumes head (pop = valid & ready)
o_queue_count  out  $clog2(QUEUE_DEPTH)+1  current occupancy
o_busy  out  1  outstanding != 0

Behaviour:
- Reset: pc=RESET_ADDR, resp_pc=RESET_ADDR, queue empty, outstanding=0, drop_cnt=0. Outputs: o_req_valid=0, o_inst_valid=0, o_queue_count=0, o_busy=0. The o_inst value is don't-care while invalid. Reset mid-operation discards all state.
- Reset has priority over redirect, which has priority over every other update.
- Request gating: o_req_valid = !i_rst && (outstanding < MAX_OUTSTANDING) && ((count + outstanding - drop_cnt) < QUEUE_DEPTH).
  - This credit rule means a live response can never find the queue full, so push-when-full is impossible.
  - o_req_addr = pc. o_req_valid and o_req_addr are combinational and stay stable while valid and not ready.
- On fire: pc <= pc+4, with 32-bit wrap (32'hFFFFFFFC -> 0).
- outstanding_next = outstanding + fire - i_resp_valid. A response with outstanding=0 is a protocol error and is ignored.
- Response when drop_cnt>0: discarded; drop_cnt decrements.
- Response when drop_cnt=0: pushes {i_resp_data, resp_pc} at the tail; resp_pc <= resp_pc+4.
- Pop: head advances. Simultaneous push and pop on a non-empty queue leaves count unchanged.
- Empty queue with a push arriving: o_inst_valid rises the next cycle. There is no bypass, so memory-to-ID latency is 1 cycle after i_resp_valid.
- Redirect cycle:
  - queue cleared (any pop that cycle is ignored);
  - pc <= target & ~3 and resp_pc <= target & ~3;
  - drop_cnt <= outstanding_next (this includes a request firing that same cycle, and excludes a response arriving that cycle, which is itself discarded);
  - o_req_valid may still fire that cycle (to the old pc); that request is counted for dropping.
- First instruction after a redirect: o_inst_valid can rise no earlier than 2 cycles after the redirect, given zero-latency memory.
- Memory stalls (i_req_ready=0) hold pc. Back-pressure from ID (i_inst_ready=0) fills the queue, after which the credit rule stops new requests.

Test Plan:
- Reset, memory always ready, 1-cycle response latency, ID always ready -> PCs 0,4,8,... appear on consecutive cycles; o_inst matches memory image.
- i_inst_ready=0 for 20 cycles, QUEUE_DEPTH=4 -> o_queue_count saturates at 4. No request fires once count+outstanding-drop_cnt reaches 4. No instruction is lost or duplicated on release.
- Two requests outstanding (to 0x10 and 0x14), then redirect to 0x103 -> both responses discarded; next o_inst_pc = 0x100; o_busy clears after the last drop.
- Redirect in the same cycle as a request fire and a response arrival -> the fired request is dropped, the arriving response is discarded, and the queue is empty the next cycle.
- Memory holds i_req_ready=0 for 5 cycles -> o_req_addr is stable across those cycles; pc advances exactly once on accept.
- RESET_ADDR=32'hFFFFFFF8 -> fetches 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000; assert i_rst while two requests are outstanding -> all outputs return to reset values the next cycle.
